// File: rtl/core_pkg.sv
// Shared constants and types for the front-end pipeline stages.
// Operation codes are opaque to issue; the enum lists the classes execute decodes.
package core_pkg;

  localparam int XLEN     = 32;
  localparam int OP_W     = 6;
  localparam int CSR_AW   = 12;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 6'd0,
    OP_ALU    = 6'd1,
    OP_ALUI   = 6'd2,
    OP_LOAD   = 6'd3,
    OP_STORE  = 6'd4,
    OP_BRANCH = 6'd5,
    OP_JUMP   = 6'd6,
    OP_CSR    = 6'd7
  } op_e;

endpackage

// File: rtl/issue_stage_scoreboard.sv
// In-flight destination tracking: one pending bit per architectural register
// plus a single outstanding-CSR flag. Sets always win over same-cycle clears.
module issue_stage_scoreboard
  import core_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_en_i,
  input  reg_idx_t set_rd_i,
  input  logic     wb_en_i,
  input  reg_idx_t wb_rd_i,
  input  logic     kill_en_i,
  input  reg_idx_t kill_rd_i,
  input  logic     csr_set_i,
  input  logic     csr_done_i,
  input  logic     csr_kill_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  input  reg_idx_t rd_i,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o,
  output logic     rd_busy_o,
  output logic     csr_busy_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                csr_busy_q, csr_busy_d;

  // A register retiring this very cycle is already considered free.
  function automatic logic reg_busy(input reg_idx_t r);
    return pending_q[r] && !(wb_en_i && (wb_rd_i == r));
  endfunction

  assign rs1_busy_o = reg_busy(rs1_i);
  assign rs2_busy_o = reg_busy(rs2_i);
  assign rd_busy_o  = reg_busy(rd_i);
  assign csr_busy_o = csr_busy_q;

  always_comb begin
    pending_d = pending_q;
    if (wb_en_i)   pending_d[wb_rd_i]   = 1'b0;
    if (kill_en_i) pending_d[kill_rd_i] = 1'b0;
    if (set_en_i)  pending_d[set_rd_i]  = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    csr_busy_d = csr_busy_q;
    if (csr_done_i || csr_kill_i) csr_busy_d = 1'b0;
    if (csr_set_i)                csr_busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      csr_busy_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      csr_busy_q <= csr_busy_d;
    end
  end

endmodule

// File: rtl/issue_stage.sv
// Issue stage: hazard check against the scoreboard, operand read with writeback
// bypass, and a single registered slot towards execute.
module issue_stage
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int OP_W   = core_pkg::OP_W,
  parameter int CSR_AW = core_pkg::CSR_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_op,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [4:0]        dec_rd,
  input  logic              dec_rd_en,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_r1_en,
  input  logic              dec_r2_en,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic              dec_csrr_en,
  input  logic [CSR_AW-1:0] dec_csrr_addr,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rd,
  output logic              ex_rd_en,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_csrr_en,
  output logic [CSR_AW-1:0] ex_csrr_addr,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              wb_csr_done,
  input  logic              flush
);

  // Handshake: a transfer happens on a clock edge where valid && ready are both
  // high; valid never waits on ready, and a held ex_* slot stays stable until taken.
  logic              ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]   ex_op_q;
  logic [XLEN-1:0]   ex_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q;
  logic [4:0]        ex_rd_q;
  logic              ex_rd_en_q, ex_csrr_en_q;
  logic [CSR_AW-1:0] ex_csrr_addr_q;

  logic rs1_busy, rs2_busy, rd_busy, csr_busy;
  logic stall, accept, kill_en, csr_kill;
  logic [XLEN-1:0] op1, op2;

  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  assign stall = (dec_r1_en && rs1_busy) || (dec_r2_en && rs2_busy)
              || (dec_rd_en && (dec_rd != 5'd0) && rd_busy)
              || (dec_csrr_en && csr_busy && !wb_csr_done);

  assign dec_ready = rst_n && !stall && !flush && (!ex_valid_q || ex_ready);
  assign accept    = dec_valid && dec_ready;

  // Squashing the held slot must release whatever it reserved.
  assign kill_en  = flush && ex_valid_q && ex_rd_en_q && (ex_rd_q != 5'd0);
  assign csr_kill = flush && ex_valid_q && ex_csrr_en_q;

  function automatic logic [XLEN-1:0] operand(input logic [4:0] rs,
                                              input logic [XLEN-1:0] rf);
    if (rs == 5'd0)                   return '0;
    else if (wb_en && (wb_rd == rs))  return wb_data;
    else                              return rf;
  endfunction

  assign op1 = operand(dec_rs1, rf_rdata1);
  assign op2 = operand(dec_rs2, rf_rdata2);

  issue_stage_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (accept && dec_rd_en && (dec_rd != 5'd0)),
    .set_rd_i   (dec_rd),
    .wb_en_i    (wb_en),
    .wb_rd_i    (wb_rd),
    .kill_en_i  (kill_en),
    .kill_rd_i  (ex_rd_q),
    .csr_set_i  (accept && dec_csrr_en),
    .csr_done_i (wb_csr_done),
    .csr_kill_i (csr_kill),
    .rs1_i      (dec_rs1),
    .rs2_i      (dec_rs2),
    .rd_i       (dec_rd),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy),
    .csr_busy_o (csr_busy)
  );

  always_comb begin
    ex_valid_d = ex_valid_q;
    if (flush)         ex_valid_d = 1'b0;
    else if (accept)   ex_valid_d = 1'b1;
    else if (ex_ready) ex_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_op_q        <= '0;
      ex_pc_q        <= '0;
      ex_rd_q        <= '0;
      ex_rd_en_q     <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_imm_q       <= '0;
      ex_csrr_en_q   <= 1'b0;
      ex_csrr_addr_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (accept) begin
        ex_op_q        <= dec_op;
        ex_pc_q        <= dec_pc;
        ex_rd_q        <= dec_rd;
        ex_rd_en_q     <= dec_rd_en;
        ex_rs1_q       <= op1;
        ex_rs2_q       <= op2;
        ex_imm_q       <= dec_imm;
        ex_csrr_en_q   <= dec_csrr_en;
        ex_csrr_addr_q <= dec_csrr_addr;
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_op        = ex_op_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rd        = ex_rd_q;
  assign ex_rd_en     = ex_rd_en_q;
  assign ex_rs1_val   = ex_rs1_q;
  assign ex_rs2_val   = ex_rs2_q;
  assign ex_imm       = ex_imm_q;
  assign ex_csrr_en   = ex_csrr_en_q;
  assign ex_csrr_addr = ex_csrr_addr_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed vector table, hand-written corner sequences,
// and randomized traffic, all checked against a rule-level reference model.
module tb_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid, dec_ready;
  logic [5:0]  dec_op;
  logic [31:0] dec_pc, dec_imm;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_rd_en, dec_r1_en, dec_r2_en, dec_csrr_en;
  logic [11:0] dec_csrr_addr;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_valid, ex_ready;
  logic [5:0]  ex_op;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_en, ex_csrr_en;
  logic [11:0] ex_csrr_addr;
  logic        wb_en, wb_csr_done, flush;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_pc(dec_pc),
    .dec_rd(dec_rd), .dec_rd_en(dec_rd_en), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_r1_en(dec_r1_en), .dec_r2_en(dec_r2_en), .dec_imm(dec_imm),
    .dec_csrr_en(dec_csrr_en), .dec_csrr_addr(dec_csrr_addr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rd_en(ex_rd_en), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_csrr_en(ex_csrr_en), .ex_csrr_addr(ex_csrr_addr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_csr_done(wb_csr_done),
    .flush(flush)
  );

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_en;
    logic [4:0]  rs1, rs2;
    logic        r1_en, r2_en;
    logic [31:0] imm;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] rf1, rf2;
    logic        ex_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_csr;
    logic        flush;
  } in_t;

  typedef struct {
    in_t         i;
    logic        exp_rdy;
    logic        exp_v;
    logic [31:0] exp_rs1;
    logic [31:0] exp_pend;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: which registers are reserved, CSR outstanding, held slot.
  bit [31:0]   m_pend;
  bit          m_csrb;
  bit          m_v;
  logic [5:0]  m_op;
  logic [31:0] m_pc, m_r1, m_r2, m_imm;
  logic [4:0]  m_rd;
  logic        m_rd_en, m_csr;
  logic [11:0] m_csra;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x = '{default: '0};
    x.ex_ready = 1'b1;
    return x;
  endfunction

  task automatic apply(input in_t x);
    dec_valid = x.valid; dec_op = x.op; dec_pc = x.pc; dec_rd = x.rd; dec_rd_en = x.rd_en;
    dec_rs1 = x.rs1; dec_rs2 = x.rs2; dec_r1_en = x.r1_en; dec_r2_en = x.r2_en;
    dec_imm = x.imm; dec_csrr_en = x.csr_en; dec_csrr_addr = x.csr_addr;
    rf_rdata1 = x.rf1; rf_rdata2 = x.rf2; ex_ready = x.ex_ready;
    wb_en = x.wb_en; wb_rd = x.wb_rd; wb_data = x.wb_data; wb_csr_done = x.wb_csr;
    flush = x.flush;
  endtask

  function automatic bit m_busy(input in_t x, input logic [4:0] r);
    return (r != 0) && m_pend[r] && !(x.wb_en && x.wb_rd == r);
  endfunction

  function automatic bit m_ready(input in_t x);
    bit hz;
    hz = (x.r1_en && m_busy(x, x.rs1)) || (x.r2_en && m_busy(x, x.rs2))
      || (x.rd_en && m_busy(x, x.rd)) || (x.csr_en && m_csrb && !x.wb_csr);
    return !hz && !x.flush && (!m_v || x.ex_ready);
  endfunction

  function automatic logic [31:0] m_opnd(input in_t x, input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'h0;
    if (x.wb_en && x.wb_rd == rs) return x.wb_data;
    return rf;
  endfunction

  task automatic check_regs();
    chk("ex_valid", ex_valid, m_v);
    chk("ex_op", ex_op, m_op);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rd", ex_rd, m_rd);
    chk("ex_rd_en", ex_rd_en, m_rd_en);
    chk("ex_rs1_val", ex_rs1_val, m_r1);
    chk("ex_rs2_val", ex_rs2_val, m_r2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_csrr_en", ex_csrr_en, m_csr);
    chk("ex_csrr_addr", ex_csrr_addr, m_csra);
    chk("pending", dut.u_sb.pending_q, m_pend);
    chk("csr_busy", dut.u_sb.csr_busy_q, m_csrb);
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic cycle(input in_t x, output logic rdy);
    bit exp_rdy, acc;
    bit [31:0] n_pend;
    bit n_csrb;
    @(negedge clk);
    apply(x);
    #1;
    exp_rdy = m_ready(x);
    chk("dec_ready", dec_ready, exp_rdy);
    chk("rf_raddr1", rf_raddr1, x.rs1);
    chk("rf_raddr2", rf_raddr2, x.rs2);
    rdy = dec_ready;
    acc = x.valid && exp_rdy;
    n_pend = m_pend;
    n_csrb = m_csrb;
    if (x.wb_en) n_pend[x.wb_rd] = 1'b0;
    if (x.flush && m_v && m_rd_en) n_pend[m_rd] = 1'b0;
    if (acc && x.rd_en) n_pend[x.rd] = 1'b1;
    n_pend[0] = 1'b0;
    if (x.wb_csr || (x.flush && m_v && m_csr)) n_csrb = 1'b0;
    if (acc && x.csr_en) n_csrb = 1'b1;
    @(posedge clk);
    #1;
    if (acc) begin
      m_op = x.op; m_pc = x.pc; m_rd = x.rd; m_rd_en = x.rd_en;
      m_r1 = m_opnd(x, x.rs1, x.rf1); m_r2 = m_opnd(x, x.rs2, x.rf2);
      m_imm = x.imm; m_csr = x.csr_en; m_csra = x.csr_addr;
    end
    if (x.flush) m_v = 1'b0;
    else if (acc) m_v = 1'b1;
    else if (x.ex_ready) m_v = 1'b0;
    m_pend = n_pend;
    m_csrb = n_csrb;
    check_regs();
  endtask

  task automatic do_reset();
    in_t x;
    x = idle();
    x.valid = 1'b1; x.rd = 5'd3; x.rd_en = 1'b1; x.pc = 32'hDEAD_0000;
    rst_n = 1'b0;
    @(negedge clk);
    apply(x);
    #1;
    chk("ready_in_reset", dec_ready, 1'b0);
    @(posedge clk);
    #1;
    m_pend = '0; m_csrb = 1'b0; m_v = 1'b0;
    m_op = '0; m_pc = '0; m_rd = '0; m_rd_en = 1'b0;
    m_r1 = '0; m_r2 = '0; m_imm = '0; m_csr = 1'b0; m_csra = '0;
    check_regs();
    rst_n = 1'b1;
    apply(idle());
  endtask

  vec_t vt[7];
  in_t  x, y;
  logic r;
  logic [31:0] s_pc, s_r1, s_imm;
  logic [4:0]  s_rd;

  initial begin
    // Directed table: ADDI, RAW stall and bypass release, x0 handling, drain.
    for (int k = 0; k < 7; k++) vt[k].i = idle();
    vt[0].i.valid = 1; vt[0].i.op = 6'd2; vt[0].i.pc = 32'h1000; vt[0].i.rd = 5; vt[0].i.rd_en = 1;
    vt[0].i.rs1 = 1; vt[0].i.r1_en = 1; vt[0].i.rf1 = 32'h10; vt[0].i.imm = 3;
    vt[0].exp_rdy = 1; vt[0].exp_v = 1; vt[0].exp_rs1 = 32'h10; vt[0].exp_pend = 32'h20;
    for (int k = 1; k < 4; k++) begin
      vt[k].i.valid = 1; vt[k].i.op = 6'd1; vt[k].i.pc = 32'h1004; vt[k].i.rd = 6; vt[k].i.rd_en = 1;
      vt[k].i.rs1 = 5; vt[k].i.r1_en = 1; vt[k].i.rf1 = 32'h99;
      vt[k].exp_rdy = 0; vt[k].exp_v = 0; vt[k].exp_rs1 = 32'h10; vt[k].exp_pend = 32'h20;
    end
    vt[3].i.wb_en = 1; vt[3].i.wb_rd = 5; vt[3].i.wb_data = 32'hABCD;
    vt[3].exp_rdy = 1; vt[3].exp_v = 1; vt[3].exp_rs1 = 32'hABCD; vt[3].exp_pend = 32'h40;
    vt[4].i.valid = 1; vt[4].i.pc = 32'h1008; vt[4].i.rd = 0; vt[4].i.rd_en = 1;
    vt[4].i.rs1 = 0; vt[4].i.r1_en = 1; vt[4].i.rf1 = 32'hFFFF_FFFF;
    vt[4].exp_rdy = 1; vt[4].exp_v = 1; vt[4].exp_rs1 = 32'h0; vt[4].exp_pend = 32'h40;
    vt[5].i.valid = 1; vt[5].i.pc = 32'h100C; vt[5].i.rs1 = 0; vt[5].i.r1_en = 1;
    vt[5].i.rs2 = 0; vt[5].i.r2_en = 1; vt[5].i.rf1 = 32'hFFFF_FFFF; vt[5].i.rf2 = 32'hFFFF_FFFF;
    vt[5].exp_rdy = 1; vt[5].exp_v = 1; vt[5].exp_rs1 = 32'h0; vt[5].exp_pend = 32'h40;
    vt[6].i.wb_en = 1; vt[6].i.wb_rd = 6;
    vt[6].exp_rdy = 1; vt[6].exp_v = 0; vt[6].exp_rs1 = 32'h0; vt[6].exp_pend = 32'h0;

    apply(idle());
    do_reset();

    for (int k = 0; k < 7; k++) begin
      cycle(vt[k].i, r);
      chk($sformatf("vec%0d_ready", k), r, vt[k].exp_rdy);
      chk($sformatf("vec%0d_ex_valid", k), ex_valid, vt[k].exp_v);
      chk($sformatf("vec%0d_rs1_val", k), ex_rs1_val, vt[k].exp_rs1);
      chk($sformatf("vec%0d_pending", k), dut.u_sb.pending_q, vt[k].exp_pend);
    end

    // Backpressure: slot must stay frozen, then reload in the release cycle.
    x = idle(); x.valid = 1; x.rd = 8; x.rd_en = 1; x.rs1 = 2; x.r1_en = 1;
    x.rf1 = 32'h55; x.pc = 32'h100; x.imm = 32'h7;
    cycle(x, r);
    chk("bp_first_ready", r, 1'b1);
    s_pc = ex_pc; s_r1 = ex_rs1_val; s_imm = ex_imm; s_rd = ex_rd;
    y = idle(); y.valid = 1; y.rd = 9; y.rd_en = 1; y.rs1 = 3; y.r1_en = 1;
    y.rf1 = 32'h66; y.pc = 32'h104; y.ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(y, r);
      chk("bp_ready_low", r, 1'b0);
      chk("bp_valid_held", ex_valid, 1'b1);
      chk("bp_pc_stable", ex_pc, s_pc);
      chk("bp_rs1_stable", ex_rs1_val, s_r1);
      chk("bp_imm_stable", ex_imm, s_imm);
      chk("bp_rd_stable", ex_rd, s_rd);
    end
    y.ex_ready = 1;
    cycle(y, r);
    chk("bp_release_ready", r, 1'b1);
    chk("bp_new_pc", ex_pc, 32'h104);
    x = idle(); x.wb_en = 1; x.wb_rd = 8; cycle(x, r);
    x.wb_rd = 9; cycle(x, r);

    // CSR serialization: second CSR waits until the first retires.
    x = idle(); x.valid = 1; x.csr_en = 1; x.csr_addr = 12'h340; x.pc = 32'h200; x.op = 6'd7;
    cycle(x, r);
    chk("csr_first_ready", r, 1'b1);
    x.pc = 32'h204;
    for (int k = 0; k < 2; k++) begin
      cycle(x, r);
      chk("csr_second_stall", r, 1'b0);
    end
    x.wb_csr = 1;
    cycle(x, r);
    chk("csr_second_ready", r, 1'b1);
    chk("csr_second_pc", ex_pc, 32'h204);
    chk("csr_busy_reset_by_new", dut.u_sb.csr_busy_q, 1'b1);
    x = idle(); x.wb_csr = 1; cycle(x, r);
    chk("csr_busy_cleared", dut.u_sb.csr_busy_q, 1'b0);

    // Flush: squash a held writer of x7, then a reader of x7 issues freely.
    x = idle(); x.valid = 1; x.rd = 7; x.rd_en = 1; x.pc = 32'h300; x.ex_ready = 0;
    cycle(x, r);
    chk("fl_hold_ready", r, 1'b1);
    y = idle(); y.valid = 1; y.rd = 10; y.rd_en = 1; y.pc = 32'h304; y.flush = 1; y.ex_ready = 0;
    cycle(y, r);
    chk("fl_no_accept", r, 1'b0);
    chk("fl_valid_cleared", ex_valid, 1'b0);
    chk("fl_pending7", dut.u_sb.pending_q[7], 1'b0);
    chk("fl_pc_unchanged", ex_pc, 32'h300);
    x = idle(); x.valid = 1; x.rs1 = 7; x.r1_en = 1; x.rf1 = 32'h77; x.pc = 32'h308;
    cycle(x, r);
    chk("fl_reader_ready", r, 1'b1);
    chk("fl_reader_rs1", ex_rs1_val, 32'h77);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      x = idle();
      x.valid    = 1'($urandom_range(0, 1));
      x.op       = 6'($urandom_range(0, 63));
      x.pc       = $urandom;
      x.rd       = 5'($urandom_range(0, 7));
      x.rd_en    = 1'($urandom_range(0, 1));
      x.rs1      = 5'($urandom_range(0, 7));
      x.rs2      = 5'($urandom_range(0, 7));
      x.r1_en    = 1'($urandom_range(0, 1));
      x.r2_en    = 1'($urandom_range(0, 1));
      x.imm      = $urandom;
      x.csr_en   = ($urandom_range(0, 5) == 0);
      x.csr_addr = 12'($urandom_range(0, 4095));
      x.rf1      = $urandom;
      x.rf2      = $urandom;
      x.ex_ready = ($urandom_range(0, 3) != 0);
      x.wb_en    = 1'($urandom_range(0, 1));
      x.wb_rd    = 5'($urandom_range(0, 7));
      x.wb_data  = $urandom;
      x.wb_csr   = ($urandom_range(0, 3) == 0);
      x.flush    = ($urandom_range(0, 15) == 0);
      cycle(x, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Sits directly downstream of the decode stage and consumes its rd/rs1/rs2, r1_en/r2_en, imm, csrr_en and csrr_addr outputs.
- Reads source operands from the register file and tracks in-flight destination registers in a 32-entry scoreboard.
- Stalls on RAW, WAW and CSR hazards.
- Launches one instruction per cycle into execute through a registered valid/ready handshake.

Parameters:
- XLEN, 32, data/immediate width
- OP_W, 6, width of the opaque decoded-operation code passed through to execute
- CSR_AW, 12, CSR address width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- dec_valid  in  1  decode has an instruction
- dec_ready  out  1  issue accepts the decode instruction this cycle
- dec_op  in  OP_W  decoded operation, passed through untouched
- dec_pc  in  XLEN  instruction PC
- dec_rd  in  5  destination register
- dec_rd_en  in  1  instruction writes rd
- dec_rs1, dec_rs2  in  5 each  source registers
- dec_r1_en, dec_r2_en  in  1 each  source is used
- dec_imm  in  XLEN  immediate
- dec_csrr_en  in  1  CSR instruction
- dec_csrr_addr  in  CSR_AW  CSR address
- rf_raddr1, rf_raddr2  out  5 each  register-file read addresses (combinational from dec_rs1/dec_rs2)
- rf_rdata1, rf_rdata2  in  XLEN each  register-file read data, same cycle
- ex_valid  out  1  issue register holds an instruction
- ex_ready  in  1  execute accepts
- ex_op  out  OP_W  registered operation
- ex_pc  out  XLEN  registered PC
- ex_rd  out  5  registered rd
- ex_rd_en  out  1  registered rd_en
- ex_rs1_val, ex_rs2_val  out  XLEN each  registered operands
- ex_imm  out  XLEN  registered immediate
- ex_csrr_en  out  1  registered CSR flag
- ex_csrr_addr  out  CSR_AW  registered CSR address
- wb_en  in  1  writeback occurring
- wb_rd  in  5  writeback register
- wb_data  in  XLEN  writeback data
- wb_csr_done  in  1  outstanding CSR instruction retired
- flush  in  1  squash the instruction held in the issue register

Behaviour:
- Reset (rst_n low at a clk edge):
  - ex_valid=0 and every ex_* data output=0.
  - Scoreboard pending[31:0]=0, csr_busy=0.
  - dec_ready is 0 during the reset cycle.
- Scoreboard:
  - pending[0] is hardwired 0.
  - A source or destination register r is busy when pending[r]=1 and not (wb_en && wb_rd==r).
- Hazard stall (combinational):
  - RAW: (dec_r1_en && busy(rs1)) or (dec_r2_en && busy(rs2)).
  - WAW: dec_rd_en && dec_rd!=0 && busy(rd).
  - CSR: dec_csrr_en && csr_busy && !wb_csr_done.
- Handshake:
  - dec_ready = !stall && !flush && (!ex_valid || ex_ready).
  - Accept = dec_valid && dec_ready. The issue register loads at that edge, so latency is 1 cycle from accept to ex_valid.
  - If ex_valid && ex_ready and there is no accept, ex_valid clears.
  - While ex_valid && !ex_ready, all ex_* outputs hold stable.
- Operand bypass: if wb_en && wb_rd==rs && rs!=0 in the accept cycle, the operand takes wb_data instead of rf_rdataN. rs==0 always yields 0.
- On accept:
  - If dec_rd_en && dec_rd!=0, set pending[dec_rd].
  - If dec_csrr_en, set csr_busy.
- On wb_en: clear pending[wb_rd]. If the same cycle sets the same bit, set wins.
- On wb_csr_done: clear csr_busy. A simultaneous CSR accept sets it again, so set wins.
- flush (priority over accept):
  - ex_valid clears next edge.
  - If the held instruction has ex_rd_en && ex_rd!=0, clear pending[ex_rd].
  - If the held instruction has ex_csrr_en, clear csr_busy.
  - No new accept in the flush cycle.
  - Instructions already handed to execute are unaffected and still write back.
- No hazard is ever raised for x0. There is no combinational path from ex_ready to ex_* data.

Decomposition:
- Shared package (core_pkg): XLEN, CSR_AW, REG_AW=5 constants; the operation enum type used for dec_op/ex_op.
- Sub-module scoreboard: 32-bit pending vector plus csr_busy; set/clear ports; busy query ports for rs1/rs2/rd.

Test Plan:
- Reset then issue ADDI x5 (rs1=x1, rf_rdata1=0x10, imm=3):
  - ex_valid=1 one cycle after accept, ex_rs1_val=0x10.
  - pending[5]=1.
- RAW stall: with pending[5]=1, present rs1=x5 and r1_en=1:
  - dec_ready=0 and stays 0.
  - Assert wb_en, wb_rd=5, wb_data=0xABCD in cycle N: accept occurs in cycle N with ex_rs1_val=0xABCD (bypass).
- x0 handling: issue with rd=x0, rd_en=1, then a reader of rs1=x0 → no stall, pending unchanged, operand 0 even when rf_rdata1=0xFFFFFFFF.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 → all ex_* outputs constant, dec_ready=0; on ex_ready=1 the next instruction loads in that same cycle.
- CSR serialization: two CSRRW back-to-back → second stalls until wb_csr_done=1, then issues in that cycle.
- Flush: holding an instruction with rd=x7, assert flush → ex_valid=0 next cycle, pending[7]=0, no accept in the flush cycle; a following reader of x7 issues without stall.
